rr_grant_arbiter: RTL and testbench

//   Round-robin arbiter sharing one resource between N_REQ requesters.

---
 rtl/arb_pkg.sv | 16 +
 rtl/lsb_prio_enc.sv | 23 ++
 rtl/rr_grant_arbiter.sv | 152 +++++++++++++++
 tb/tb_rr_grant_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state type and one-hot helper for the round-robin grant arbiter
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Widest requester vector the helper can encode; callers size-cast the result down.
  localparam int unsigned ARB_MAX_N = 64;

  function automatic logic [ARB_MAX_N-1:0] onehot(input logic [31:0] idx);
    return ARB_MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// rtl/lsb_prio_enc.sv - lowest-set-bit priority encoder
module lsb_prio_enc #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin arbiter with registered one-hot grant and hold timeout
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16,
  parameter int IDX_W    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  localparam int              HC_W      = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;

  logic             owner_req;
  logic             release_c;
  logic             timeout_c;
  logic             take_c;
  logic [N_REQ-1:0] owner_oh;
  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] mask_above;
  logic [N_REQ-1:0] masked_req;
  logic [N_REQ-1:0] win_oh;
  logic [IDX_W-1:0] m_idx, u_idx, win_idx;
  logic             m_valid, u_valid, win_valid;

  assign owner_oh  = N_REQ'(onehot(32'(idx_q)));
  assign owner_req = req[idx_q];
  assign release_c = (state_q == BUSY) && !owner_req;
  // A release wins over a timeout simply because a timeout needs the owner still requesting.
  assign timeout_c = (state_q == BUSY) && owner_req && (hold_cnt_q == HOLD_LAST);
  assign arb_req   = timeout_c ? (req & ~owner_oh) : req;

  always_comb begin
    mask_above = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mask_above[i] = (IDX_W'(i) > ptr_q);
    end
  end

  assign masked_req = arb_req & mask_above;

  lsb_prio_enc #(
    .N (N_REQ),
    .W (IDX_W)
  ) u_enc_masked (
    .vec   (masked_req),
    .idx   (m_idx),
    .valid (m_valid)
  );

  lsb_prio_enc #(
    .N (N_REQ),
    .W (IDX_W)
  ) u_enc_full (
    .vec   (arb_req),
    .idx   (u_idx),
    .valid (u_valid)
  );

  assign win_valid = u_valid;
  assign win_idx   = m_valid ? m_idx : u_idx;
  assign win_oh    = N_REQ'(onehot(32'(win_idx)));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    valid_d    = valid_q;
    take_c     = 1'b0;

    case (state_q)
      IDLE: begin
        take_c = win_valid;
      end
      BUSY: begin
        if (release_c) begin
          if (win_valid) begin
            take_c = 1'b1;
          end else begin
            state_d    = IDLE;
            grant_d    = '0;
            valid_d    = 1'b0;
            hold_cnt_d = '0;
          end
        end else if (timeout_c) begin
          if (win_valid) begin
            take_c = 1'b1;
          end else begin
            // Sole requester keeps the resource; pointer already names it.
            hold_cnt_d = '0;
          end
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take_c) begin
      state_d    = BUSY;
      ptr_d      = win_idx;
      idx_d      = win_idx;
      hold_cnt_d = '0;
      grant_d    = win_oh;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_RST;
      idx_q      <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  a_valid_match:   assert property (@(posedge clk) disable iff (!rst_n) valid_q == (grant_q != '0));

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - directed vector table, reset corners and randomized model check
module tb_rr_grant_arbiter;

  localparam int N    = 8;
  localparam int MAXH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] grant_idx;

  int checks;
  int errors;

  rr_grant_arbiter #(
    .N_REQ    (N),
    .MAX_HOLD (MAXH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] req;
    logic [7:0] grant;
    logic       valid;
    logic [2:0] idx;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [7:0] r, input logic [7:0] g,
                              input logic v, input logic [2:0] i);
    vec_t e;
    e.req   = r;
    e.grant = g;
    e.valid = v;
    e.idx   = i;
    tbl.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] g, input logic v, input logic [2:0] i);
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_valid"}, 32'(grant_valid), 32'(v));
    check({tag, "_idx"}, 32'(grant_idx), 32'(i));
  endtask

  // Reference model: owner as an integer (-1 = none), cycles held so far, rotation pointer.
  int m_owner, m_held, m_ptr, m_idx;

  function automatic int search(input logic [7:0] r, input int p, input int excl);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_grant(input int w);
    m_owner = w;
    m_ptr   = w;
    m_idx   = w;
    m_held  = 1;
  endtask

  task automatic model_step(input logic [7:0] r);
    int w;
    if (m_owner < 0) begin
      w = search(r, m_ptr, -1);
      if (w >= 0) model_grant(w);
    end else if (!r[m_owner]) begin
      w = search(r, m_ptr, -1);
      if (w >= 0) model_grant(w);
      else m_owner = -1;
    end else if (m_held == MAXH) begin
      w = search(r, m_ptr, m_owner);
      if (w >= 0) model_grant(w);
      else m_held = 1;
    end else begin
      m_held++;
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = N - 1;
    m_idx   = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_g;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 8'h00;

    // Directed table, derived by hand from reset (ptr = 7, idle), MAX_HOLD = 4.
    repeat (5) add(8'h00, 8'h00, 1'b0, 3'd0);
    repeat (3) add(8'h01, 8'h01, 1'b1, 3'd0);
    add(8'h00, 8'h00, 1'b0, 3'd0);
    for (int o = 1; o <= 8; o++) begin
      repeat (4) add(8'hFF, 8'h01 << (o % 8), 1'b1, 3'(o % 8));
    end
    add(8'hFF, 8'h02, 1'b1, 3'd1);
    add(8'h00, 8'h00, 1'b0, 3'd1);
    add(8'h10, 8'h10, 1'b1, 3'd4);
    add(8'h00, 8'h00, 1'b0, 3'd4);
    add(8'h24, 8'h20, 1'b1, 3'd5);
    add(8'h00, 8'h00, 1'b0, 3'd5);
    add(8'h24, 8'h04, 1'b1, 3'd2);
    add(8'h00, 8'h00, 1'b0, 3'd2);
    add(8'h80, 8'h80, 1'b1, 3'd7);
    add(8'h05, 8'h01, 1'b1, 3'd0);
    add(8'h04, 8'h04, 1'b1, 3'd2);
    add(8'h00, 8'h00, 1'b0, 3'd2);
    repeat (12) add(8'h08, 8'h08, 1'b1, 3'd3);
    add(8'h00, 8'h00, 1'b0, 3'd3);
    add(8'h01, 8'h01, 1'b1, 3'd0);
    add(8'h03, 8'h01, 1'b1, 3'd0);
    add(8'h07, 8'h01, 1'b1, 3'd0);
    repeat (4) add(8'h06, 8'h02, 1'b1, 3'd1);
    add(8'h06, 8'h04, 1'b1, 3'd2);
    add(8'h00, 8'h00, 1'b0, 3'd2);

    repeat (3) @(negedge clk);
    check_out("reset", 8'h00, 1'b0, 3'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      req = tbl[i].req;
      @(posedge clk);
      @(negedge clk);
      check_out($sformatf("tbl%0d", i), tbl[i].grant, tbl[i].valid, tbl[i].idx);
    end

    // Reset asserted between edges while BUSY drops the grant at once.
    req = 8'h10;
    @(posedge clk);
    @(negedge clk);
    check_out("pre_rst", 8'h10, 1'b1, 3'd4);
    #2 rst_n = 1'b0;
    #1 check_out("mid_rst", 8'h00, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h81;
    @(posedge clk);
    @(negedge clk);
    check_out("post_rst", 8'h01, 1'b1, 3'd0);
    req = 8'h80;
    @(posedge clk);
    @(negedge clk);
    check_out("post_rst7", 8'h80, 1'b1, 3'd7);

    // Randomized traffic against the rotation model.
    do_reset();
    model_reset();
    req = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 9))
        0:       req = 8'($urandom);
        1:       req = req ^ (8'h01 << $urandom_range(0, 7));
        2:       req = 8'h00;
        3:       req = 8'($urandom) & 8'($urandom);
        default: req = req;
      endcase
      @(posedge clk);
      model_step(req);
      @(negedge clk);
      exp_g = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
      check_out($sformatf("rnd%0d", c), exp_g, m_owner >= 0, 3'(m_idx));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
